// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use / branch-operand hazard detection and bubble insertion.
// Optional performance counters are enabled by defining IDEX_PERF_CNT_EN.
module idex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RegWrite,
    input  logic          ALUSrc,
    input  logic          RegDst,
    input  logic          MemtoReg,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic          Branch,
    input  logic [1:0]    ALUop,
    input  logic          ID_Flush,
    input  logic [DW-1:0] ReadData1,
    input  logic [DW-1:0] ReadData2,
    input  logic [DW-1:0] SignExt,
    input  logic [RW-1:0] Rs,
    input  logic [RW-1:0] Rt,
    input  logic [RW-1:0] Rd,
    input  logic          MEM_MemRead,
    input  logic [RW-1:0] MEM_Rt,
    output logic          EX_RegWrite,
    output logic          EX_ALUSrc,
    output logic          EX_RegDst,
    output logic          EX_MemtoReg,
    output logic          EX_MemWrite,
    output logic          EX_MemRead,
    output logic [1:0]    EX_ALUop,
    output logic [DW-1:0] EX_A,
    output logic [DW-1:0] EX_B,
    output logic [DW-1:0] EX_Imm,
    output logic [RW-1:0] EX_Rs,
    output logic [RW-1:0] EX_Rt,
    output logic [RW-1:0] EX_Rd,
`ifdef IDEX_PERF_CNT_EN
    output logic [15:0]   StallCnt,
    output logic [15:0]   BubbleCnt,
`endif
    output logic          Stall
);

    logic [RW-1:0] ex_dst;
    logic          lu_hazard;
    logic          ex_dep;
    logic          mem_dep;
    logic          br_hazard;
    logic          bubble;

    assign ex_dst    = EX_RegDst ? EX_Rd : EX_Rt;
    assign lu_hazard = EX_MemRead && (EX_Rt != '0) && ((EX_Rt == Rs) || (EX_Rt == Rt));
    assign ex_dep    = EX_RegWrite && (ex_dst != '0) && ((ex_dst == Rs) || (ex_dst == Rt));
    assign mem_dep   = MEM_MemRead && (MEM_Rt != '0) && ((MEM_Rt == Rs) || (MEM_Rt == Rt));
    assign br_hazard = Branch && (ex_dep || mem_dep);

    // A flush wins over a hazard so fetch is free to redirect; the bubble still goes in.
    assign Stall  = (lu_hazard || br_hazard) && !ID_Flush;
    assign bubble = Stall || ID_Flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            EX_RegWrite <= 1'b0;
            EX_ALUSrc   <= 1'b0;
            EX_RegDst   <= 1'b0;
            EX_MemtoReg <= 1'b0;
            EX_MemWrite <= 1'b0;
            EX_MemRead  <= 1'b0;
            EX_ALUop    <= '0;
            EX_A        <= '0;
            EX_B        <= '0;
            EX_Imm      <= '0;
            EX_Rs       <= '0;
            EX_Rt       <= '0;
            EX_Rd       <= '0;
        end else begin
            if (bubble) begin
                EX_RegWrite <= 1'b0;
                EX_ALUSrc   <= 1'b0;
                EX_RegDst   <= 1'b0;
                EX_MemtoReg <= 1'b0;
                EX_MemWrite <= 1'b0;
                EX_MemRead  <= 1'b0;
                EX_ALUop    <= '0;
            end else begin
                EX_RegWrite <= RegWrite;
                EX_ALUSrc   <= ALUSrc;
                EX_RegDst   <= RegDst;
                EX_MemtoReg <= MemtoReg;
                EX_MemWrite <= MemWrite;
                EX_MemRead  <= MemRead;
                EX_ALUop    <= ALUop;
            end
            EX_A   <= ReadData1;
            EX_B   <= ReadData2;
            EX_Imm <= SignExt;
            EX_Rs  <= Rs;
            EX_Rt  <= Rt;
            EX_Rd  <= Rd;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCnt  <= '0;
            BubbleCnt <= '0;
        end else begin
            if (Stall && (StallCnt != '1)) StallCnt <= StallCnt + 16'd1;
            if (bubble && (BubbleCnt != '1)) BubbleCnt <= BubbleCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed hazard scenarios plus randomized traffic
// checked against a behavioural pipeline model (counters checked when IDEX_PERF_CNT_EN is defined).
module tb_idex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          RegWrite, ALUSrc, RegDst, MemtoReg, MemWrite, MemRead, Branch;
    logic [1:0]    ALUop;
    logic          ID_Flush;
    logic [DW-1:0] ReadData1, ReadData2, SignExt;
    logic [RW-1:0] Rs, Rt, Rd;
    logic          MEM_MemRead;
    logic [RW-1:0] MEM_Rt;
    logic          EX_RegWrite, EX_ALUSrc, EX_RegDst, EX_MemtoReg, EX_MemWrite, EX_MemRead;
    logic [1:0]    EX_ALUop;
    logic [DW-1:0] EX_A, EX_B, EX_Imm;
    logic [RW-1:0] EX_Rs, EX_Rt, EX_Rd;
    logic          Stall;
`ifdef IDEX_PERF_CNT_EN
    logic [15:0]   StallCnt, BubbleCnt;
    int unsigned   m_scnt, m_bcnt;
`endif

    idex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .MemRead(MemRead), .Branch(Branch), .ALUop(ALUop),
        .ID_Flush(ID_Flush), .ReadData1(ReadData1), .ReadData2(ReadData2), .SignExt(SignExt),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .MEM_MemRead(MEM_MemRead), .MEM_Rt(MEM_Rt),
        .EX_RegWrite(EX_RegWrite), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
        .EX_MemtoReg(EX_MemtoReg), .EX_MemWrite(EX_MemWrite), .EX_MemRead(EX_MemRead),
        .EX_ALUop(EX_ALUop), .EX_A(EX_A), .EX_B(EX_B), .EX_Imm(EX_Imm),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
`ifdef IDEX_PERF_CNT_EN
        .StallCnt(StallCnt), .BubbleCnt(BubbleCnt),
`endif
        .Stall(Stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int obs_stalls = 0;
    bit known = 0;
    bit mem_auto = 1;

    // Model of the instruction held in EX: control word {RegWrite,ALUSrc,RegDst,MemtoReg,MemWrite,MemRead,ALUop}
    logic [7:0]    m_ctrl;
    logic [DW-1:0] m_a, m_b, m_imm;
    logic [RW-1:0] m_rs, m_rt, m_rd;

    function automatic bit reads(input logic [RW-1:0] r);
        return (r != 0) && (r == Rs || r == Rt);
    endfunction

    function automatic bit model_stall();
        logic [RW-1:0] dst;
        bit lu, br;
        dst = m_ctrl[5] ? m_rd : m_rt;
        lu  = m_ctrl[2] && reads(m_rt);
        br  = Branch && ((m_ctrl[7] && reads(dst)) || (MEM_MemRead && reads(MEM_Rt)));
        return (lu || br) && !ID_Flush;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit s_exp, b_exp, ld_in_ex;
        logic [RW-1:0] ld_rt;
        @(negedge clk);
        s_exp = model_stall();
        b_exp = s_exp || ID_Flush;
        if (known) check("stall", 128'(Stall), 128'(s_exp));
        if (Stall === 1'b1) obs_stalls++;
        ld_in_ex = m_ctrl[2];
        ld_rt    = m_rt;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_ctrl = '0; m_a = '0; m_b = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
            known = 1;
`ifdef IDEX_PERF_CNT_EN
            m_scnt = 0; m_bcnt = 0;
`endif
        end else begin
            m_ctrl = b_exp ? 8'h00 : {RegWrite, ALUSrc, RegDst, MemtoReg, MemWrite, MemRead, ALUop};
            m_a = ReadData1; m_b = ReadData2; m_imm = SignExt;
            m_rs = Rs; m_rt = Rt; m_rd = Rd;
`ifdef IDEX_PERF_CNT_EN
            if (s_exp && m_scnt < 65535) m_scnt++;
            if (b_exp && m_bcnt < 65535) m_bcnt++;
`endif
        end
        if (known) begin
            check("ex_ctrl", 128'({EX_RegWrite, EX_ALUSrc, EX_RegDst, EX_MemtoReg, EX_MemWrite,
                                   EX_MemRead, EX_ALUop}), 128'(m_ctrl));
            check("ex_data", {EX_A, EX_B, EX_Imm, 17'd0, EX_Rs, EX_Rt, EX_Rd},
                             {m_a, m_b, m_imm, 17'd0, m_rs, m_rt, m_rd});
`ifdef IDEX_PERF_CNT_EN
            check("stall_cnt", 128'(StallCnt), 128'(m_scnt));
            check("bubble_cnt", 128'(BubbleCnt), 128'(m_bcnt));
`endif
        end
        // The load that was in EX moves to MEM (bubbles carry MemRead=0)
        if (mem_auto) begin
            MEM_MemRead = rst_n ? ld_in_ex : 1'b0;
            MEM_Rt      = ld_rt;
        end
    endtask

    task automatic nop();
        {RegWrite, ALUSrc, RegDst, MemtoReg, MemWrite, MemRead, Branch} = '0;
        ALUop = '0; ID_Flush = 0;
        ReadData1 = $urandom; ReadData2 = $urandom; SignExt = $urandom;
        Rs = '0; Rt = '0; Rd = '0;
    endtask

    task automatic lw(input logic [RW-1:0] dst);
        nop();
        RegWrite = 1; ALUSrc = 1; MemtoReg = 1; MemRead = 1; Rs = 5'd1; Rt = dst;
    endtask

    task automatic alu(input logic [RW-1:0] src, input logic [RW-1:0] dst);
        nop();
        RegWrite = 1; RegDst = 1; ALUop = 2'b10; Rs = src; Rt = 5'd2; Rd = dst;
    endtask

    task automatic beq(input logic [RW-1:0] src);
        nop();
        Branch = 1; ALUop = 2'b01; Rs = src; Rt = 5'd0;
    endtask

    task automatic randomize_inputs();
        {RegWrite, ALUSrc, RegDst, MemtoReg, MemWrite, MemRead, Branch} = 7'($urandom);
        ALUop = 2'($urandom);
        ID_Flush = ($urandom_range(0, 9) == 0);
        ReadData1 = $urandom; ReadData2 = $urandom; SignExt = $urandom;
        Rs = 5'($urandom_range(0, 3)); Rt = 5'($urandom_range(0, 3)); Rd = 5'($urandom_range(0, 3));
        rst_n = ($urandom_range(0, 49) != 0);
    endtask

`ifdef IDEX_PERF_CNT_EN
    logic [15:0] snap_s, snap_b;
`endif

    initial begin
        m_ctrl = 'x; m_a = 'x; m_b = 'x; m_imm = 'x; m_rs = 'x; m_rt = 'x; m_rd = 'x;
        MEM_MemRead = 0; MEM_Rt = '0;

        // Reset with arbitrary inputs
        rst_n = 0;
        randomize_inputs();
        rst_n = 0;
        step();
        randomize_inputs();
        rst_n = 0;
        step();
        check("reset_stall", 128'(Stall), 128'(0));
        rst_n = 1;

        // Load-use: one stall, bubble, then replay passes through
        lw(5'd8); step();
        alu(5'd8, 5'd9);
        obs_stalls = 0;
        step();
        check("lu_bubble", 128'({EX_RegWrite, EX_RegDst, EX_ALUop}), 128'(0));
        step();
        check("lu_replay", 128'({EX_RegWrite, EX_RegDst, EX_ALUop}), 128'(4'b1110));
        check("lu_stalls", 128'(obs_stalls), 128'(1));

        // Load then beq: two stalls, two bubbles
        lw(5'd8); step();
`ifdef IDEX_PERF_CNT_EN
        snap_s = StallCnt; snap_b = BubbleCnt;
`endif
        beq(5'd8);
        obs_stalls = 0;
        step(); step(); step();
        check("lw_beq_stalls", 128'(obs_stalls), 128'(2));
`ifdef IDEX_PERF_CNT_EN
        check("lw_beq_scnt", 128'(StallCnt - snap_s), 128'(2));
        check("lw_beq_bcnt", 128'(BubbleCnt - snap_b), 128'(2));
`endif

        // ALU then dependent beq: one stall
        alu(5'd3, 5'd10); step();
        beq(5'd10);
        obs_stalls = 0;
        step(); step();
        check("alu_beq_stalls", 128'(obs_stalls), 128'(1));

        // Register zero never hazards
        lw(5'd0); step();
        alu(5'd0, 5'd11);
        obs_stalls = 0;
        step();
        check("r0_stalls", 128'(obs_stalls), 128'(0));
        check("r0_pass", 128'(EX_RegWrite), 128'(1));

        // Flush overrides hazard but still bubbles
        lw(5'd8); step();
`ifdef IDEX_PERF_CNT_EN
        snap_s = StallCnt; snap_b = BubbleCnt;
`endif
        alu(5'd8, 5'd9); ID_Flush = 1;
        obs_stalls = 0;
        step();
        check("flush_stalls", 128'(obs_stalls), 128'(0));
        check("flush_bubble", 128'(EX_RegWrite), 128'(0));
`ifdef IDEX_PERF_CNT_EN
        check("flush_scnt", 128'(StallCnt - snap_s), 128'(0));
        check("flush_bcnt", 128'(BubbleCnt - snap_b), 128'(1));
`endif

        // Reset asserted during a stall clears the hazard
        lw(5'd8); step();
        alu(5'd8, 5'd9);
        rst_n = 0;
        step();
        rst_n = 1;
        obs_stalls = 0;
        step();
        check("rst_mid_stall", 128'(obs_stalls), 128'(0));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step();
        end
        rst_n = 1;

`ifdef IDEX_PERF_CNT_EN
        // Saturation: permanent branch-on-load hazard via MEM
        nop(); step();
        mem_auto = 0;
        MEM_MemRead = 1; MEM_Rt = 5'd8;
        beq(5'd8);
        for (int i = 0; i < 70000; i++) step();
        check("sat_scnt", 128'(StallCnt), 128'(16'hFFFF));
        step(); step();
        check("sat_hold", 128'(StallCnt), 128'(16'hFFFF));
        mem_auto = 1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
